// File: rtl/qspi_stream_fifo.sv
// Width-converting FIFO: IN_W-bit pushes stored as OUT_W-bit symbols, one symbol per pop.
// Optional recent-data snapshot on `window` is built when QSPI_STREAM_FIFO_WINDOW_EN is defined.
module qspi_stream_fifo #(
  parameter int DEPTH     = 24,
  parameter int IN_W      = 4,
  parameter int OUT_W     = 2,
  parameter int AFULL_LVL = 20,
  parameter int WINDOW    = 16,
  localparam int RATIO    = IN_W / OUT_W,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic [IN_W-1:0]           push_data,
  input  logic                      pop,
  output logic [OUT_W-1:0]          pop_data,
  output logic                      pop_valid,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic [CW-1:0]             count,
  output logic                      overflow,
  output logic                      underflow,
  output logic [WINDOW*OUT_W-1:0]   window
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             push_acc;
  logic             pop_acc;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Flags come from the registered count only; no path from push/pop.
  assign empty       = (count == '0);
  assign full        = (count > CW'(DEPTH - RATIO));
  assign almost_full = (count >= CW'(AFULL_LVL));
  assign push_acc    = push && !full && !clear;
  assign pop_acc     = pop && !empty && !clear;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (push_acc) count_next = count_next + CW'(RATIO);
    if (pop_acc)  count_next = count_next - CW'(1);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      pop_valid <= pop_acc;
      if (push_acc) wr_ptr <= wrap_add(wr_ptr, RATIO);
      if (pop_acc) begin
        rd_ptr   <= wrap_add(rd_ptr, 1);
        pop_data <= mem[rd_ptr];
      end
      if (push && full)  overflow  <= 1'b1;
      if (pop && empty)  underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      for (int i = 0; i < RATIO; i++)
        mem[wrap_add(wr_ptr, i)] <= push_data[IN_W-1-i*OUT_W -: OUT_W];
    end
  end

`ifdef QSPI_STREAM_FIFO_WINDOW_EN
  logic [WINDOW*OUT_W-1:0] shadow;

  // Unaffected by clear: only rst wipes the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           shadow <= '0;
    else if (push_acc) shadow <= {shadow[WINDOW*OUT_W-IN_W-1:0], push_data};
  end

  assign window = shadow;
`else
  assign window = '0;
`endif

endmodule
